casee_pri_enc: RTL and testbench

//   Registered N-to-log2(N) priority encoder; default is 4-to-2. Reports the

---
 rtl/casee_pkg.sv | 16 +
 rtl/casee_pri_enc_if.sv | 19 +
 rtl/casee_pri_comb.sv | 26 ++
 rtl/casee_pri_enc.sv | 58 +++++
 tb/tb_casee_pri_enc.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/casee_pkg.sv
// Shared definitions for the casee priority encoder slice.
// Holds the default request width and a width helper for the encoded index.
// Imported by the interface, the combinational core and the top.
package casee_pkg;

  localparam int DEF_WIDTH = 4;

  // Index width for an n-bit request vector; never narrower than one bit.
  function automatic int clog2_safe(int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/casee_pri_enc_if.sv
// Request/result bundle for the priority encoder.
// master drives the request vector; slave (the encoder) returns index + valid.
// No handshake: the vector is sampled every cycle.
interface casee_pri_enc_if
  import casee_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  localparam int OUT_W = clog2_safe(WIDTH);

  logic [WIDTH-1:0] x;
  logic [OUT_W-1:0] y;
  logic             valid;

  modport master (output x, input y, input valid);
  modport slave  (input x, output y, output valid);

endinterface

// File: rtl/casee_pri_comb.sv
// Combinational priority encode: index of the highest set bit plus any-set flag.
// Latency: zero (pure combinational).
// Backpressure: none; output follows the input continuously.
module casee_pri_comb
  import casee_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OUT_W = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  // Scan upwards so the highest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    any = |x;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        idx = OUT_W'(i);
      end
    end
  end

endmodule

// File: rtl/casee_pri_enc.sv
// Registered priority encoder: y = index of highest set bit of x, valid = |x.
// Latency: one clock from x to y/valid.
// Backpressure: none; x is sampled on every rising edge.
module casee_pri_enc
  import casee_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  casee_pri_enc_if.slave bus
);

  localparam int OUT_W = clog2_safe(WIDTH);

  logic [OUT_W-1:0] idx;
  logic             any;

  casee_pri_comb #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_comb (
    .x   (bus.x),
    .idx (idx),
    .any (any)
  );

  // Output stage: reset clears immediately; y is forced to 0 when nothing is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y     <= '0;
      bus.valid <= 1'b0;
    end else begin
      bus.y     <= any ? idx : '0;
      bus.valid <= any;
    end
  end

`ifdef CASEE_ASSERT
  logic [WIDTH-1:0] x_q;

  // Copy of the sampled request vector, aligned with the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
    end else begin
      x_q <= bus.x;
    end
  end

  a_idle_zero : assert property (@(posedge clk) disable iff (rst)
    !bus.valid |-> (bus.y == '0));

  a_hit_top : assert property (@(posedge clk) disable iff (rst)
    bus.valid |-> (x_q[bus.y] && ((x_q >> bus.y) == WIDTH'(1))));
`endif

endmodule

// File: tb/tb_casee_pri_enc.sv
// Directed bench for casee_pri_enc at WIDTH 4, 8 and 5.
// Checks reset, zero input, one-hot, priority, latency, mid-run reset, exhaustive.
// Results are compared against hand values and a small reference function.
module tb_casee_pri_enc;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  casee_pri_enc_if #(.WIDTH(4)) if4 ();
  casee_pri_enc_if #(.WIDTH(8)) if8 ();
  casee_pri_enc_if #(.WIDTH(5)) if5 ();

  casee_pri_enc #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  casee_pri_enc #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
  casee_pri_enc #(.WIDTH(5)) u5 (.clk(clk), .rst(rst), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the highest set bit of the low w bits of v, or 0 when none set.
  function automatic int ref_idx(int v, int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq_x [6];
  logic [1:0] seq_y [6];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    if4.x  = '0;
    if8.x  = '0;
    if5.x  = '0;

    // 1. Reset asserted between edges takes effect with no clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_async_y", {6'b0, if4.y}, 8'd0);
    chk("rst_async_valid", {7'b0, if4.valid}, 8'd0);
    if4.x = 4'b1111;
    if8.x = 8'hff;
    if5.x = 5'h1f;
    repeat (3) cyc();
    chk("rst_hold_y", {6'b0, if4.y}, 8'd0);
    chk("rst_hold_valid", {7'b0, if4.valid}, 8'd0);
    chk("rst_hold_y8", {5'b0, if8.y}, 8'd0);
    rst   = 1'b0;
    if4.x = 4'b0000;
    if8.x = 8'h00;
    if5.x = 5'h00;

    // 2. Zero input.
    cyc();
    chk("zero_y", {6'b0, if4.y}, 8'd0);
    chk("zero_valid", {7'b0, if4.valid}, 8'd0);

    // 3. One-hot sweep.
    for (int i = 0; i < 4; i++) begin
      if4.x = 4'(1 << i);
      cyc();
      chk($sformatf("onehot%0d_y", i), {6'b0, if4.y}, 8'(i));
      chk($sformatf("onehot%0d_valid", i), {7'b0, if4.valid}, 8'd1);
    end

    // 4. Priority among multiple set bits.
    if4.x = 4'b1010; cyc(); chk("pri_1010", {6'b0, if4.y}, 8'd3); chk("pri_1010_v", {7'b0, if4.valid}, 8'd1);
    if4.x = 4'b0110; cyc(); chk("pri_0110", {6'b0, if4.y}, 8'd2); chk("pri_0110_v", {7'b0, if4.valid}, 8'd1);
    if4.x = 4'b1111; cyc(); chk("pri_1111", {6'b0, if4.y}, 8'd3); chk("pri_1111_v", {7'b0, if4.valid}, 8'd1);
    if4.x = 4'b0011; cyc(); chk("pri_0011", {6'b0, if4.y}, 8'd1); chk("pri_0011_v", {7'b0, if4.valid}, 8'd1);

    // 5a. Latency: y holds the previous result until the next edge.
    seq_x[0] = 4'b0001; seq_y[0] = 2'd0;
    seq_x[1] = 4'b1000; seq_y[1] = 2'd3;
    seq_x[2] = 4'b0101; seq_y[2] = 2'd2;
    seq_x[3] = 4'b0010; seq_y[3] = 2'd1;
    seq_x[4] = 4'b1100; seq_y[4] = 2'd3;
    seq_x[5] = 4'b0111; seq_y[5] = 2'd2;
    for (int k = 0; k < 6; k++) begin
      if4.x = seq_x[k];
      #2;
      chk($sformatf("lat%0d_before", k), {6'b0, if4.y}, (k == 0) ? 8'd1 : 8'(seq_y[k-1]));
      cyc();
      chk($sformatf("lat%0d_after", k), {6'b0, if4.y}, 8'(seq_y[k]));
    end

    // 5b. Reset mid-operation while y=3.
    if4.x = 4'b1000;
    cyc();
    chk("mid_pre_y", {6'b0, if4.y}, 8'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_y", {6'b0, if4.y}, 8'd0);
    chk("mid_rst_valid", {7'b0, if4.valid}, 8'd0);
    cyc();
    rst   = 1'b0;
    if4.x = 4'b0100;
    cyc();
    chk("mid_rel_y", {6'b0, if4.y}, 8'd2);
    chk("mid_rel_valid", {7'b0, if4.valid}, 8'd1);

    // 6. Wider and non-power-of-2 instances: directed points.
    if8.x = 8'h90;
    if5.x = 5'b10000;
    cyc();
    chk("w8_90", {5'b0, if8.y}, 8'd7);
    chk("w8_90_v", {7'b0, if8.valid}, 8'd1);
    chk("w5_10000", {5'b0, if5.y}, 8'd4);
    chk("w5_10000_v", {7'b0, if5.valid}, 8'd1);

    // 6. Exhaustive sweep of all three instances against the reference.
    for (int v = 0; v < 256; v++) begin
      if4.x = 4'(v);
      if8.x = 8'(v);
      if5.x = 5'(v);
      cyc();
      if (v < 16) begin
        chk($sformatf("ex4_%0d_y", v), {6'b0, if4.y}, 8'(ref_idx(v, 4)));
        chk($sformatf("ex4_%0d_v", v), {7'b0, if4.valid}, 8'(v != 0));
      end
      if (v < 32) begin
        chk($sformatf("ex5_%0d_y", v), {5'b0, if5.y}, 8'(ref_idx(v, 5)));
        chk($sformatf("ex5_%0d_v", v), {7'b0, if5.valid}, 8'(v != 0));
      end
      chk($sformatf("ex8_%0d_y", v), {5'b0, if8.y}, 8'(ref_idx(v, 8)));
      chk($sformatf("ex8_%0d_v", v), {7'b0, if8.valid}, 8'(v != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
